// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if
//   Valid/ready stream carrying words read out of the feature-map BRAM.
//   m_valid  beat valid (source -> sink)
//   m_ready  sink ready (sink -> source)
//   m_data   beat data, DATA_W bits (source -> sink)
//   m_last   final beat of the job (source -> sink)
interface bram_stream_reader_if #(
    parameter int unsigned DATA_W = 32
);
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Read-side engine for the single-port feature-map BRAM (1-cycle read
//   latency). On an accepted start it walks num_words byte addresses from
//   base_addr by stride_bytes and streams the words out through a 2-entry
//   FIFO, never issuing a read while the BRAM is in write mode.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_start           1-cycle job start, accepted only when idle
//   i_base_addr       first byte address          (sampled on accepted start)
//   i_stride_bytes    byte step between words     (sampled on accepted start)
//   i_num_words       words to stream             (sampled on accepted start)
//   o_busy            job in progress (RUN / DRAIN)
//   o_done            1-cycle end-of-job pulse
//   i_wr_active       BRAM write cycle; blocks read issue
//   o_rd_addr         BRAM read byte address
//   i_bram_dout       BRAM read data, valid 1 cycle after issue
//   m                 output stream (master side)
module bram_stream_reader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_stride_bytes,
    input  logic [CNT_W-1:0]  i_num_words,
    output logic              o_busy,
    output logic              o_done,
    input  logic              i_wr_active,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_bram_dout,
    bram_stream_reader_if.master m
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_stride;
    logic [CNT_W-1:0]  r_n;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_popped;
    logic              r_inflight;
    logic [DATA_W-1:0] r_fifo [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_cnt;

    logic              w_valid;
    logic              w_pop;
    logic [2:0]        w_occ;
    logic              w_issue;
    logic              w_accept;
    logic              w_last_issue;
    logic              w_last_beat;

    assign w_valid      = (r_cnt != 2'd0);
    assign w_pop        = w_valid && m.m_ready;
    // Occupancy after this cycle's pop, counting the word still in the BRAM
    // pipeline; keeping it below 2 guarantees the FIFO cannot overflow.
    assign w_occ        = {1'b0, r_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue      = (r_state == S_RUN) && !i_wr_active && (w_occ < 3'd2);
    assign w_accept     = (r_state == S_IDLE) && i_start;
    assign w_last_issue = w_issue && (r_issued == r_n - CNT_W'(1));
    assign w_last_beat  = (r_popped == r_n - CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_num_words == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last_issue) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && w_last_beat) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= '0;
            r_stride   <= '0;
            r_n        <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_inflight <= 1'b0;
            r_fifo[0]  <= '0;
            r_fifo[1]  <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_cnt      <= 2'd0;
        end else begin
            if (w_accept) begin
                r_stride <= i_stride_bytes;
                r_n      <= i_num_words;
                r_issued <= '0;
                r_popped <= '0;
                // A zero-length job leaves the read address untouched.
                if (i_num_words != '0) begin
                    r_addr <= i_base_addr;
                end
            end

            if (w_issue) begin
                r_addr   <= r_addr + r_stride;
                r_issued <= r_issued + CNT_W'(1);
            end

            r_inflight <= w_issue;

            if (r_inflight) begin
                r_fifo[r_wr_ptr] <= i_bram_dout;
                r_wr_ptr         <= ~r_wr_ptr;
            end

            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
                r_popped <= r_popped + CNT_W'(1);
            end

            r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

    // The address register drives the BRAM directly, so the address is
    // already on the bus in the issue cycle itself.
    assign o_rd_addr = r_addr;
    assign o_busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_done    = (r_state == S_DONE);
    assign m.m_valid = w_valid;
    assign m.m_data  = r_fifo[r_rd_ptr];
    assign m.m_last  = w_valid && w_last_beat;

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [19:0] base_addr;
    logic [19:0] stride_bytes;
    logic [15:0] num_words;
    logic        busy;
    logic        done;
    logic        wr_active;
    logic [19:0] rd_addr;
    logic [31:0] bram_dout;

    bram_stream_reader_if #(.DATA_W(32)) s_if ();

    bram_stream_reader #(
        .DATA_W(32),
        .ADDR_W(20),
        .CNT_W (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .i_base_addr   (base_addr),
        .i_stride_bytes(stride_bytes),
        .i_num_words   (num_words),
        .o_busy        (busy),
        .o_done        (done),
        .i_wr_active   (wr_active),
        .o_rd_addr     (rd_addr),
        .i_bram_dout   (bram_dout),
        .m             (s_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM content: every word is distinct and nonzero.
    function automatic logic [31:0] bram_word(input logic [17:0] idx);
        return 32'hC0DE_0000 + {14'd0, idx};
    endfunction

    // Single-port BRAM model: 1-cycle read latency, no read in write cycles.
    always @(posedge clk) begin
        if (!wr_active) bram_dout <= bram_word(rd_addr[19:2]);
    end

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [19:0] addr_log [64];
    int          done_cyc;
    int          done_cnt;
    int          nbeats;
    int          busy_cnt;
    int          first_beat;
    int          last_cyc;

    // Runs one job starting at posedge+1. Cycle 0 is the start cycle.
    task automatic run_job(input logic [19:0] base, input logic [19:0] stride,
                           input logic [15:0] n,
                           input int rdy_lo_from, input int rdy_lo_to,
                           input int wr_from, input int wr_to,
                           input int again_cyc, input int rst_cyc);
        logic [19:0] a;
        logic        prev_hold;
        logic [31:0] prev_data;
        logic        prev_last;
        exp_t        e;
        done_cyc = -1; done_cnt = 0; nbeats = 0; busy_cnt = 0;
        first_beat = -1; last_cyc = -1;
        for (int i = 0; i < 64; i++) addr_log[i] = '0;
        a = base;
        for (int k = 0; k < int'(n); k++) begin
            e.data = bram_word(a[19:2]);
            e.last = (k == int'(n) - 1);
            sb.push_back(e);
            a = a + stride;
        end
        prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0;
        for (int c = 0; c < 64; c++) begin
            start        = (c == 0) || (c == again_cyc);
            base_addr    = (c == again_cyc) ? 20'h0AAA0 : base;
            stride_bytes = (c == again_cyc) ? 20'h00010 : stride;
            num_words    = (c == again_cyc) ? 16'd9 : n;
            s_if.m_ready = !(c >= rdy_lo_from && c <= rdy_lo_to);
            wr_active    = (c >= wr_from && c <= wr_to);
            if (c == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
                checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %0b expected 0", done); end
                checks++; if (rd_addr !== 20'h0) begin errors++; $display("FAIL midrst_rd_addr: got %0h expected 0", rd_addr); end
                checks++; if (s_if.m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid: got %0b expected 0", s_if.m_valid); end
                checks++; if (s_if.m_data !== 32'h0) begin errors++; $display("FAIL midrst_m_data: got %0h expected 0", s_if.m_data); end
                checks++; if (s_if.m_last !== 1'b0) begin errors++; $display("FAIL midrst_m_last: got %0b expected 0", s_if.m_last); end
                sb.delete();
                start = 1'b0; wr_active = 1'b0; s_if.m_ready = 1'b1;
                return;
            end
            @(negedge clk);
            addr_log[c] = rd_addr;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin done_cnt++; done_cyc = c; end
            if (prev_hold) begin
                checks++;
                if (s_if.m_valid !== 1'b1 || s_if.m_data !== prev_data || s_if.m_last !== prev_last) begin
                    errors++;
                    $display("FAIL hold_stable c%0d: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b",
                             c, s_if.m_valid, s_if.m_data, s_if.m_last, prev_data, prev_last);
                end
            end
            prev_hold = (s_if.m_valid === 1'b1) && !s_if.m_ready;
            prev_data = s_if.m_data;
            prev_last = s_if.m_last;
            if (s_if.m_valid === 1'b1 && s_if.m_ready) begin
                nbeats++;
                if (first_beat < 0) first_beat = c;
                if (s_if.m_last === 1'b1) last_cyc = c;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat c%0d: got d=%0h expected no beat", c, s_if.m_data);
                end else begin
                    e = sb.pop_front();
                    if (s_if.m_data !== e.data || s_if.m_last !== e.last) begin
                        errors++;
                        $display("FAIL beat c%0d: got d=%0h l=%0b expected d=%0h l=%0b",
                                 c, s_if.m_data, s_if.m_last, e.data, e.last);
                    end
                end
            end
            @(posedge clk); #1;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        start = 1'b0; s_if.m_ready = 1'b1; wr_active = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_beats: got %0d left expected 0", sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; wr_active = 1'b0; s_if.m_ready = 1'b1;
        base_addr = '0; stride_bytes = '0; num_words = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b expected 0", done); end
        checks++; if (rd_addr !== 20'h0) begin errors++; $display("FAIL rst_rd_addr: got %0h expected 0", rd_addr); end
        checks++; if (s_if.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid: got %0b expected 0", s_if.m_valid); end
        checks++; if (s_if.m_data !== 32'h0) begin errors++; $display("FAIL rst_m_data: got %0h expected 0", s_if.m_data); end
        checks++; if (s_if.m_last !== 1'b0) begin errors++; $display("FAIL rst_m_last: got %0b expected 0", s_if.m_last); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_len();
        run_job(20'h00080, 20'h4, 16'd0, -1, -1, -1, -1, -1, -1);
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cyc: got %0d expected 1", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL zero_busy: got %0d expected 0", busy_cnt); end
        checks++; if (nbeats != 0) begin errors++; $display("FAIL zero_beats: got %0d expected 0", nbeats); end
        checks++; if (addr_log[2] !== 20'h0) begin errors++; $display("FAIL zero_rd_addr: got %0h expected 0", addr_log[2]); end
    endtask

    task automatic test_stream();
        // A second start in cycle 2 carries different parameters and must be ignored.
        run_job(20'h00040, 20'h4, 16'd4, -1, -1, -1, -1, 2, -1);
        checks++; if (addr_log[1] !== 20'h40) begin errors++; $display("FAIL str_addr1: got %0h expected 40", addr_log[1]); end
        checks++; if (addr_log[2] !== 20'h44) begin errors++; $display("FAIL str_addr2: got %0h expected 44", addr_log[2]); end
        checks++; if (addr_log[3] !== 20'h48) begin errors++; $display("FAIL str_addr3: got %0h expected 48", addr_log[3]); end
        checks++; if (addr_log[4] !== 20'h4C) begin errors++; $display("FAIL str_addr4: got %0h expected 4c", addr_log[4]); end
        checks++; if (first_beat != 3) begin errors++; $display("FAIL str_first_beat: got %0d expected 3", first_beat); end
        checks++; if (last_cyc != 6) begin errors++; $display("FAIL str_last_cyc: got %0d expected 6", last_cyc); end
        checks++; if (done_cyc != 7) begin errors++; $display("FAIL str_done_cyc: got %0d expected 7", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL str_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (busy_cnt != 6) begin errors++; $display("FAIL str_busy_cnt: got %0d expected 6", busy_cnt); end
    endtask

    task automatic test_backpressure();
        run_job(20'h00040, 20'h4, 16'd4, 3, 8, -1, -1, -1, -1);
        checks++; if (addr_log[3] !== 20'h48) begin errors++; $display("FAIL bp_addr3: got %0h expected 48", addr_log[3]); end
        checks++; if (addr_log[8] !== 20'h48) begin errors++; $display("FAIL bp_addr8: got %0h expected 48", addr_log[8]); end
        checks++; if (addr_log[10] !== 20'h4C) begin errors++; $display("FAIL bp_addr10: got %0h expected 4c", addr_log[10]); end
        checks++; if (nbeats != 4) begin errors++; $display("FAIL bp_beats: got %0d expected 4", nbeats); end
        checks++; if (first_beat != 9) begin errors++; $display("FAIL bp_first_beat: got %0d expected 9", first_beat); end
        checks++; if (done_cyc != 13) begin errors++; $display("FAIL bp_done_cyc: got %0d expected 13", done_cyc); end
    endtask

    task automatic test_wr_yield();
        run_job(20'h00040, 20'h4, 16'd4, -1, -1, 2, 3, -1, -1);
        checks++; if (addr_log[3] !== 20'h44) begin errors++; $display("FAIL wr_addr3: got %0h expected 44", addr_log[3]); end
        checks++; if (addr_log[4] !== 20'h44) begin errors++; $display("FAIL wr_addr4: got %0h expected 44", addr_log[4]); end
        checks++; if (addr_log[5] !== 20'h48) begin errors++; $display("FAIL wr_addr5: got %0h expected 48", addr_log[5]); end
        checks++; if (nbeats != 4) begin errors++; $display("FAIL wr_beats: got %0d expected 4", nbeats); end
        checks++; if (done_cyc != 9) begin errors++; $display("FAIL wr_done_cyc: got %0d expected 9", done_cyc); end
    endtask

    task automatic test_wrap();
        run_job(20'hFFFF8, 20'h4, 16'd4, -1, -1, -1, -1, -1, -1);
        checks++; if (addr_log[1] !== 20'hFFFF8) begin errors++; $display("FAIL wrap_addr1: got %0h expected ffff8", addr_log[1]); end
        checks++; if (addr_log[2] !== 20'hFFFFC) begin errors++; $display("FAIL wrap_addr2: got %0h expected ffffc", addr_log[2]); end
        checks++; if (addr_log[3] !== 20'h00000) begin errors++; $display("FAIL wrap_addr3: got %0h expected 0", addr_log[3]); end
        checks++; if (addr_log[4] !== 20'h00004) begin errors++; $display("FAIL wrap_addr4: got %0h expected 4", addr_log[4]); end
        checks++; if (done_cyc != 7) begin errors++; $display("FAIL wrap_done_cyc: got %0d expected 7", done_cyc); end
    endtask

    task automatic test_reset_midjob();
        run_job(20'h00040, 20'h4, 16'd4, -1, -1, -1, -1, -1, 4);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(20'h00100, 20'h8, 16'd3, -1, -1, -1, -1, -1, -1);
        checks++; if (addr_log[1] !== 20'h100) begin errors++; $display("FAIL rj_addr1: got %0h expected 100", addr_log[1]); end
        checks++; if (addr_log[3] !== 20'h110) begin errors++; $display("FAIL rj_addr3: got %0h expected 110", addr_log[3]); end
        checks++; if (nbeats != 3) begin errors++; $display("FAIL rj_beats: got %0d expected 3", nbeats); end
        checks++; if (first_beat != 3) begin errors++; $display("FAIL rj_first_beat: got %0d expected 3", first_beat); end
        checks++; if (done_cyc != 6) begin errors++; $display("FAIL rj_done_cyc: got %0d expected 6", done_cyc); end
    endtask

    initial begin
        bram_dout = '0;
        test_reset();
        test_zero_len();
        test_stream();
        test_backpressure();
        test_wr_yield();
        test_wrap();
        test_reset_midjob();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
